// File: rtl/fft_pkg.sv
// Shared constants for the 64-point FFT datapath.
// Sample word layout: complex re/im packed into one word.
package fft_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAME_LEN  = 8;
  localparam int IDX_W      = 3;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic word_t cplx_pack(
    input logic [RE_MSB-RE_LSB:0] re,
    input logic [IM_MSB-IM_LSB:0] im
  );
    word_t w;
    w = '0;
    w[RE_MSB:RE_LSB] = re;
    w[IM_MSB:IM_LSB] = im;
    return w;
  endfunction

endpackage

// File: rtl/s2p_bank.sv
// One frame bank: N words plus a written mask.
// Unwritten positions read as zero on the parallel outputs.
module s2p_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8,
  parameter int IW         = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [IW-1:0]                idx_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         clr_i,
  output logic [N-1:0][DATA_WIDTH-1:0] q_o
);

  logic [N-1:0][DATA_WIDTH-1:0] word_q, word_d;
  logic [N-1:0]                 mask_q, mask_d;

  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = '0;
    end
    if (we_i) begin
      word_d[idx_i] = data_i;
      mask_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      mask_q <= '0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    q_o = '0;
    for (int k = 0; k < N; k++) begin
      q_o[k] = mask_q[k] ? word_q[k] : '0;
    end
  end

endmodule

// File: rtl/s2p_frame_buffer.sv
// Serial-to-parallel ping-pong frame buffer feeding the
// commutator's parallel-load inputs.
module s2p_frame_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Q0,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic [DATA_WIDTH-1:0] Q2,
  output logic [DATA_WIDTH-1:0] Q3,
  output logic [DATA_WIDTH-1:0] Q4,
  output logic [DATA_WIDTH-1:0] Q5,
  output logic [DATA_WIDTH-1:0] Q6,
  output logic [DATA_WIDTH-1:0] Q7,
  output logic                  frame_err
);

  import fft_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             err_q, err_d;

  logic acc, commit, pop, at_end;

  logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] bq0, bq1, rq;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign frame_err = err_q;

  assign acc    = in_valid & in_ready;
  assign at_end = (wr_idx_q == LAST_IDX);
  assign commit = acc & (at_end | in_last);
  assign pop    = out_valid & out_ready;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    err_d     = err_q;
    if (acc) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (in_last != at_end) begin
        err_d = 1'b1;
      end
    end
    // commit and pop always target different banks
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_idx_d          = '0;
    end
    if (pop) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
    end
  end

  s2p_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (FRAME_LEN),
    .IW         (IDX_W)
  ) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (acc & ~wr_bank_q),
    .idx_i  (wr_idx_q),
    .data_i (in_data),
    .clr_i  (pop & ~rd_bank_q),
    .q_o    (bq0)
  );

  s2p_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (FRAME_LEN),
    .IW         (IDX_W)
  ) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (acc & wr_bank_q),
    .idx_i  (wr_idx_q),
    .data_i (in_data),
    .clr_i  (pop & rd_bank_q),
    .q_o    (bq1)
  );

  assign rq = rd_bank_q ? bq1 : bq0;

  assign Q0 = rq[0];
  assign Q1 = rq[1];
  assign Q2 = rq[2];
  assign Q3 = rq[3];
  assign Q4 = rq[4];
  assign Q5 = rq[5];
  assign Q6 = rq[6];
  assign Q7 = rq[7];

endmodule

// File: doc/s2p_frame_buffer.md
Name: s2p_frame_buffer

Overview:
- Input stage directly upstream of the 8-segment commutator buffer in the 64-point FFT datapath.
- Collects a serial stream of complex samples (32-bit, re/im packed) into 8-word frames using ping-pong double buffering.
- Presents each completed frame as eight parallel words Q0..Q7, which feed the commutator's parallel-load inputs D0..D7, under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of one complex sample word.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_data is valid this cycle.
- in_ready, output, 1, block can accept a sample this cycle.
- in_data, input, DATA_WIDTH, serial sample.
- in_last, input, 1, marks the 8th (final) sample of a frame.
- out_valid, output, 1, a complete frame is presented on Q0..Q7.
- out_ready, input, 1, downstream loads the frame this cycle.
- Q0..Q7, output, DATA_WIDTH each, frame words; Q0 is the first sample accepted, Q7 the last.
- frame_err, output, 1, sticky flag for in_last/position mismatch.

Behaviour:
- Reset (async, immediate on rst=1):
  - Both bank-full flags = 0, wr_bank = 0, rd_bank = 0, wr_idx = 0, written masks = 0, frame_err = 0.
  - Therefore out_valid = 0, in_ready = 1, Q0..Q7 = 0.
  - Reset mid-frame discards the partial frame and any pending full frame.
- Storage:
  - Two banks of 8 words, each with an 8-bit written mask.
  - Qk = mask[rd_bank][k] ? word[rd_bank][k] : 0.
  - Q0..Q7 are driven combinationally from registers only; there is no combinational path from in_* to Q*.
- Write side:
  - Accept = in_valid & in_ready.
  - in_ready = !full[wr_bank]; it depends on registered state only, never combinationally on out_ready.
  - On accept: word[wr_bank][wr_idx] <= in_data, mask bit set, wr_idx increments.
- Frame commit (at the accepting edge), when the accept has wr_idx == 7 or in_last = 1:
  - full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
- Boundary cases:
  - in_last with wr_idx < 7 (early last): frame committed; unwritten positions read as 0 through the mask; frame_err <= 1.
  - wr_idx == 7 without in_last (missing last): frame committed; frame_err <= 1.
  - frame_err clears only on reset.
- Read side:
  - out_valid = full[rd_bank].
  - Pop = out_valid & out_ready: full[rd_bank] <= 0, mask[rd_bank] <= 0, rd_bank toggles.
  - Q then shows the other bank (valid or zeros).
  - out_ready while out_valid = 0 has no effect.
- Simultaneous events: a commit into one bank and a pop from the other in the same cycle both take effect. Commit and pop can never target the same bank, because a write requires !full and a pop requires full.
- Latency and throughput:
  - Final sample accepted at edge N gives out_valid = 1 after edge N (visible in cycle N+1).
  - With out_ready held high, sustained rate is 1 sample/cycle and in_ready never drops.
- Backpressure:
  - With both banks full, in_ready = 0 and input stalls.
  - in_ready returns to 1 the cycle after the first pop.

Decomposition:
- Shared package fft_pkg:
  - DATA_WIDTH default 32
  - FRAME_LEN = 8
  - IDX_W = 3
  - complex-word field positions (re = [31:16], im = [15:0])
- Sub-module s2p_bank: one 8-word bank with write enable/index, written mask, clear, and masked parallel outputs. Instantiated twice.
- Top level holds wr_bank, rd_bank, wr_idx, full flags, frame_err, and the output mux.

Test Plan:
1. After reset, stream 8 samples 0x00010001..0x00080008 with in_last on the 8th and out_ready = 0 -> out_valid = 1 the next cycle; Q0 = 0x00010001 ... Q7 = 0x00080008; frame_err = 0; in_ready stays 1.
2. Continuous 4 frames with in_valid = 1 and out_ready = 1 -> in_ready never 0; each frame pops 1 cycle after its last sample; word order is preserved per frame.
3. out_ready = 0; send 16 samples -> both banks full and in_ready = 0 after the 16th accept. Pulse out_ready -> first frame popped, in_ready = 1 next cycle, second frame then on Q.
4. in_last on the 5th sample (0xA..0xE) -> frame committed, Q0..Q4 = 0xA..0xE, Q5..Q7 = 0, frame_err = 1; the next frame starts at Q0.
5. 8 samples with in_last = 0 -> frame committed, frame_err = 1, Q0..Q7 hold the data.
6. Assert rst after 3 samples with one full frame pending -> out_valid = 0, in_ready = 1, Q* = 0 immediately. A fresh 8-sample frame then completes correctly.
